// File: rtl/pipelined_conv_datapath.sv
// Pipelined fixed-point convolution datapath.
// One KERNEL_SIZE x KERNEL_SIZE dot product plus bias per transfer.
// Pipeline: product stage, binary adder tree with one register per level,
// then a shift/format stage.
// Optional build macro CONV_DP_SATURATE_EN: when defined, the shifted sum is
// clamped to the DATA_WIDTH signed range and overflow flags clipping. When
// undefined, the low DATA_WIDTH bits are output and overflow is tied to 0.

// Single multiplier lane: full-precision signed product, sign-extended to the
// accumulator width so the adder tree can treat every leaf uniformly.
module conv_mul_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = 37
) (
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0] p_i,
  output logic [ACC_W-1:0]      prod_o
);
  logic [2*DATA_WIDTH-1:0] prod;

  // Sign-extend both operands so the low 2*DATA_WIDTH bits of the unsigned
  // product equal the signed product.
  assign prod   = {{DATA_WIDTH{w_i[DATA_WIDTH-1]}}, w_i} *
                  {{DATA_WIDTH{p_i[DATA_WIDTH-1]}}, p_i};
  assign prod_o = {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
endmodule

module pipelined_conv_datapath #(
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
  input  logic [DATA_WIDTH-1:0]                         bias,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_WIDTH-1:0]                         result,
  output logic                                          overflow
);
  localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int L      = $clog2(N + 1);        // adder tree levels
  localparam int P      = 1 << L;               // leaves padded to a power of two
  localparam int ACC_W  = 2*DATA_WIDTH + L;     // wide enough for N+1 full products
  localparam int STAGES = L + 2;                // product + tree levels + output

  logic                   en;
  logic [STAGES-1:0]      vld_q;
  logic [N-1:0][ACC_W-1:0] prod;
  logic [P-1:0][ACC_W-1:0] leaf_d;
  logic [ACC_W-1:0]       bias_ext;
  // Heap-ordered tree: node 0 is the root, leaves live at P-1 .. 2P-2.
  logic [2*P-2:0][ACC_W-1:0] node_q;
  logic [ACC_W-1:0]       shifted;
  logic [DATA_WIDTH-1:0]  res_d, result_q;
  logic                   ovf_d, ovf_q;

  // The whole pipeline freezes only when a finished result is being refused.
  assign en        = ~(vld_q[STAGES-1] & ~out_ready);
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES-1];
  assign result    = result_q;
  assign overflow  = ovf_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    conv_mul_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(ACC_W)) u_lane (
      .w_i    (weights   [i*DATA_WIDTH +: DATA_WIDTH]),
      .p_i    (pixel_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .prod_o (prod[i])
    );
  end

  assign bias_ext = {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};

  // Leaf vector: N products, the bias aligned to product scale, zero padding.
  always_comb begin
    leaf_d = '0;
    for (int i = 0; i < N; i++) leaf_d[i] = prod[i];
    leaf_d[N] = bias_ext << FRAC_BITS;
  end

  // Valid shift register; a 0 bit is a bubble that never reaches the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_q <= '0;
    else if (en) vld_q <= {vld_q[STAGES-2:0], in_valid};
  end

  // Product registers plus one register per tree level; every internal node
  // sums its two children from the previous cycle, so the root lags the
  // leaves by exactly L cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q <= '0;
    end else if (en) begin
      for (int j = 0; j < P-1; j++) node_q[j] <= node_q[2*j+1] + node_q[2*j+2];
      for (int i = 0; i < P; i++)   node_q[P-1+i] <= leaf_d[i];
    end
  end

  // Drop the extra fractional bits; arithmetic shift floors toward -inf.
  assign shifted = $signed(node_q[0]) >>> FRAC_BITS;

`ifdef CONV_DP_SATURATE_EN
  // Clamp when the bits above the result sign are not all sign copies.
  always_comb begin
    res_d = shifted[DATA_WIDTH-1:0];
    ovf_d = 1'b0;
    if (shifted[ACC_W-1:DATA_WIDTH-1] != {(ACC_W-DATA_WIDTH+1){shifted[ACC_W-1]}}) begin
      ovf_d = 1'b1;
      res_d = shifted[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign res_d     = shifted[DATA_WIDTH-1:0];
  assign ovf_d     = 1'b0;
  assign unused_hi = ^shifted[ACC_W-1:DATA_WIDTH];
`endif

  // Output register; holds while stalled so the consumer sees a stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      result_q <= res_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pipelined_conv_datapath.sv
// Directed bench for pipelined_conv_datapath at default parameters.
module tb_pipelined_conv_datapath;
  localparam int N  = 25;
  localparam int DW = 16;

  logic            clk, rst_n;
  logic [N*DW-1:0] weights, pixel_data;
  logic [DW-1:0]   bias, result;
  logic            in_valid, in_ready, out_valid, out_ready, overflow;

  int passed = 0;
  int total  = 0;

  pipelined_conv_datapath dut (
    .clk(clk), .rst_n(rst_n), .weights(weights), .pixel_data(pixel_data),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] w, input logic [DW-1:0] p, input logic [DW-1:0] b);
    for (int i = 0; i < N; i++) begin
      weights[i*DW +: DW]    = w;
      pixel_data[i*DW +: DW] = p;
    end
    bias = b;
  endtask

  // One isolated transfer: result must appear exactly 7 cycles later.
  task automatic single(input string tag, input logic [DW-1:0] w, input logic [DW-1:0] p,
                        input logic [DW-1:0] b, input logic [DW-1:0] er, input logic eo);
    load(w, p, b);
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      #1;
      chk($sformatf("%s_vld_c%0d", tag, t), 32'(out_valid), 32'(t == 7));
      if (t == 7) begin
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    load(16'h0, 16'h0, 16'h0);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Basic sums, bias, negative weights, floor rounding.
    single("ones",     16'h0100, 16'h0200, 16'h0000, 16'h3200, 1'b0);
    single("bias",     16'h0100, 16'h0200, 16'h0180, 16'h3380, 1'b0);
    single("negw",     16'hFF00, 16'h0200, 16'h0000, 16'hCE00, 1'b0);
    single("floor",    16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
`ifdef CONV_DP_SATURATE_EN
    single("satpos",   16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1);
    single("satneg",   16'h8000, 16'h7FFF, 16'h0000, 16'h8000, 1'b1);
`else
    single("wrappos",  16'h7FFF, 16'h7FFF, 16'h0000, 16'hE700, 1'b0);
    single("wrapneg",  16'h8000, 16'h7FFF, 16'h0000, 16'h0C80, 1'b0);
`endif

    // Ten back-to-back transfers; k-th result is k*0x190.
    for (int t = 0; t <= 16; t++) begin
      if (t < 10) begin
        load(16'h0100, 16'((t+1)*16'h0010), 16'h0000);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t < 10) chk($sformatf("b2b_in_ready_c%0d", t), 32'(in_ready), 32'd1);
      if (t >= 7) begin
        chk($sformatf("b2b_vld_c%0d", t), 32'(out_valid), 32'd1);
        chk($sformatf("b2b_res_c%0d", t), 32'(result), 32'((t-6)*16'h0190));
      end else if (t >= 1) begin
        chk($sformatf("b2b_vld_c%0d", t), 32'(out_valid), 32'd0);
      end
      tick();
    end
    #1;
    chk("b2b_drained", 32'(out_valid), 32'd0);
    tick();

    // Three transfers against a refusing consumer, released at cycle 11.
    out_ready = 1'b0;
    for (int t = 0; t <= 14; t++) begin
      if (t < 3) begin
        load(16'h0100, 16'((t+1)*16'h0010), 16'h0000);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (t == 11) out_ready = 1'b1;
      #1;
      if (t >= 1 && t <= 6) begin
        chk($sformatf("stl_vld_c%0d", t), 32'(out_valid), 32'd0);
        chk($sformatf("stl_rdy_c%0d", t), 32'(in_ready), 32'd1);
      end else if (t >= 7 && t <= 11) begin
        chk($sformatf("stl_vld_c%0d", t), 32'(out_valid), 32'd1);
        chk($sformatf("stl_res_c%0d", t), 32'(result), 32'h0190);
        chk($sformatf("stl_rdy_c%0d", t), 32'(in_ready), 32'(t == 11));
      end else if (t == 12 || t == 13) begin
        chk($sformatf("stl_vld_c%0d", t), 32'(out_valid), 32'd1);
        chk($sformatf("stl_res_c%0d", t), 32'(result), 32'((t-10)*16'h0190));
      end else if (t == 14) begin
        chk("stl_drained", 32'(out_valid), 32'd0);
      end
      tick();
    end

    // Reset three cycles after a transfer; that transfer must vanish.
    load(16'h0100, 16'h0200, 16'h0000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_result",    32'(result),    32'd0);
    chk("midrst_overflow",  32'(overflow),  32'd0);
    tick();
    chk("midrst_hold_vld",  32'(out_valid), 32'd0);
    rst_n = 1'b1;
    // Input presented right away must be taken on the first edge.
    single("postrst", 16'h0100, 16'h0200, 16'h0180, 16'h3380, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipelined_conv_datapath.md
PIPELINED_CONV_DATAPATH -- requirements
Module: pipelined_conv_datapath

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 5: kernel edge length; the block computes N = KERNEL_SIZE**2 products.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: signed fixed-point width of weights, pixels, bias and result.
REQ-003 SHALL have parameter FRAC_BITS, default 8: fractional bits of every operand and of the result (Q8.8 at defaults).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port weights, input, N*DATA_WIDTH bits: element i is at bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
REQ-007 SHALL have port pixel_data, input, N*DATA_WIDTH bits: same packing as weights, signed.
REQ-008 SHALL have port bias, input, DATA_WIDTH bits: signed, same Q format as the operands.
REQ-009 SHALL have port in_valid, input, 1 bit: weights, pixel_data and bias are valid this cycle.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-011 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-013 SHALL have port result, output, DATA_WIDTH bits: signed convolution output.
REQ-014 SHALL have port overflow, output, 1 bit: the current result was clipped; qualified by out_valid.

Function
REQ-015 SHALL accept an input transfer on a cycle where in_valid and in_ready are both 1.
REQ-016 SHALL form each product at full 2*DATA_WIDTH signed precision and register it in stage 1.
REQ-017 SHALL include the bias as leaf N+1, sign-extended and shifted left by FRAC_BITS.
REQ-018 SHALL sum the N+1 leaves in a binary adder tree with one register per level (L = ceil(log2(N+1)) levels).
REQ-019 SHALL use an accumulator width of 2*DATA_WIDTH+L bits so that no internal overflow occurs.
REQ-020 SHALL arithmetic-right-shift the sum by FRAC_BITS (truncation toward minus infinity) in a final registered stage.
REQ-021 SHALL have a fixed latency LAT = L+2 cycles from acceptance to out_valid when out_ready is held at 1 (7 cycles at the defaults).
REQ-022 SHALL carry one valid bit per stage; an empty stage is a bubble and produces no output.
REQ-023 SHALL stall the whole pipeline when out_valid=1 and out_ready=0, and SHALL drive in_ready = !(out_valid && !out_ready).
REQ-024 SHALL hold result, overflow and out_valid stable while stalled, and SHALL not drop or duplicate any transfer.
REQ-025 SHALL sustain one transfer per cycle when in_valid and out_ready are held at 1.
REQ-026 SHALL accept a new input and retire an output in the same cycle without a bubble.

Reset
REQ-027 SHALL, while rst_n=0, clear all stage valid bits and drive out_valid=0, result=0, overflow=0 and in_ready=1.
REQ-028 SHALL discard all in-flight data on reset mid-operation; no stale result appears after rst_n returns high.
REQ-029 SHALL accept input on the first rising clock edge after rst_n deasserts.

Configuration
REQ-030 SHALL, when macro CONV_DP_SATURATE_EN is defined, clamp the shifted sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and set overflow=1 whenever clamping occurs.
REQ-031 SHALL, when CONV_DP_SATURATE_EN is undefined, output the low DATA_WIDTH bits of the shifted sum (wrap-around) and tie overflow to 0.

Verification
REQ-032 SHALL pass: all weights 0x0100 (1.0), pixels 0x0200 (2.0), bias 0, one transfer -> result 0x3200 (50.0) with out_valid exactly 7 cycles later and overflow 0.
REQ-033 SHALL pass: as REQ-032 with bias 0x0180 (1.5) -> 0x3380; weights 0xFF00 (-1.0), bias 0 -> 0xCE00 (-50.0).
REQ-034 SHALL pass: all weights and pixels 0x7FFF -> 0x7FFF with overflow=1 when saturation is enabled; the low 16 bits of the shifted sum with overflow=0 when disabled.
REQ-035 SHALL pass: 10 back-to-back transfers with out_ready=1 -> 10 results on consecutive cycles, in order.
REQ-036 SHALL pass: 3 transfers, then out_ready=0 for 4 cycles -> in_ready=0, first result held, then all 3 results delivered in order.
REQ-037 SHALL pass: rst_n pulsed low 3 cycles after a transfer -> out_valid stays 0 and no result appears for that transfer.
